// File: rtl/toy_bus_pkg.sv
// Shared ToyBus definitions: request field widths, default ID width, opcode
// encoding and the two-way round-robin pick used by ToyBus merge nodes.
package toy_bus_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned STRB_W   = 32;
  localparam int unsigned SB_W     = 32;
  localparam int unsigned OPC_W    = 1;
  localparam int unsigned ID_W_DEF = 4;

  typedef enum logic [OPC_W-1:0] {
    OpRead  = 1'b0,
    OpWrite = 1'b1
  } toy_bus_op_e;

  // One-hot grant for two requesters. On contention the index after
  // last_grant wins; a sole requester wins regardless of last_grant.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last_grant);
    if (req == 2'b11) begin
      return last_grant ? 2'b01 : 2'b10;
    end
    return req;
  endfunction

endpackage

// File: rtl/toy_bus_rr_arb2.sv
// Two-way round-robin arbiter with a 1-bit last_grant register.
// Ports:
//   clk      - clock, state on rising edge
//   rst_n    - asynchronous active-low reset (last_grant resets to 1)
//   req      - request vector, bit i from requester i
//   advance  - a granted request was accepted this cycle; commit the winner
//   grant    - one-hot grant, combinational from req and last_grant only
module toy_bus_rr_arb2
  import toy_bus_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_q, last_d;

  always_comb begin
    grant = rr_pick(req, last_q);
  end

  // last_grant only moves on an accepted request, so a stalled winner keeps
  // its grant until it completes.
  always_comb begin
    last_d = last_q;
    if (advance && (grant != 2'b00)) begin
      last_d = grant[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/toy_bus_arb_node_dmem_req.sv
// Merges two ToyBus request streams (in0, in1) into one stream toward dmem
// using round-robin arbitration. Payload fields pass through unmodified.
// Configuration macro: TOY_BUS_ARB_OUT_REG_EN
//   defined   - registered output slice, 1-cycle latency, full throughput
//   undefined - combinational pass-through, 0-cycle latency
// Ports:
//   clk, rst_n           - clock and asynchronous active-low reset
//   in0_* / in1_*        - initiator request channels (vld/rdy + payload)
//   out0_*               - merged request channel toward dmem
module toy_bus_arb_node_dmem_req
  import toy_bus_pkg::*;
#(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned ID_W   = ID_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              in0_vld,
  output logic              in0_rdy,
  input  logic [ADDR_W-1:0] in0_addr,
  input  logic [STRB_W-1:0] in0_strb,
  input  logic [DATA_W-1:0] in0_data,
  input  logic [OPC_W-1:0]  in0_opcode,
  input  logic [ID_W-1:0]   in0_src_id,
  input  logic [ID_W-1:0]   in0_tgt_id,
  input  logic [SB_W-1:0]   in0_sideband,

  input  logic              in1_vld,
  output logic              in1_rdy,
  input  logic [ADDR_W-1:0] in1_addr,
  input  logic [STRB_W-1:0] in1_strb,
  input  logic [DATA_W-1:0] in1_data,
  input  logic [OPC_W-1:0]  in1_opcode,
  input  logic [ID_W-1:0]   in1_src_id,
  input  logic [ID_W-1:0]   in1_tgt_id,
  input  logic [SB_W-1:0]   in1_sideband,

  output logic              out0_vld,
  input  logic              out0_rdy,
  output logic [ADDR_W-1:0] out0_addr,
  output logic [STRB_W-1:0] out0_strb,
  output logic [DATA_W-1:0] out0_data,
  output logic [OPC_W-1:0]  out0_opcode,
  output logic [ID_W-1:0]   out0_src_id,
  output logic [ID_W-1:0]   out0_tgt_id,
  output logic [SB_W-1:0]   out0_sideband
);

  localparam int unsigned PlW = ADDR_W + STRB_W + DATA_W + OPC_W + 2 * ID_W + SB_W;

  logic [1:0]     grant;
  logic           slot_rdy;
  logic           in_hs;
  logic [PlW-1:0] pl0, pl1, pl_mux, pl_out;

  toy_bus_rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({in1_vld, in0_vld}),
    .advance (in_hs),
    .grant   (grant)
  );

  always_comb begin
    pl0 = {in0_addr, in0_strb, in0_data, in0_opcode, in0_src_id, in0_tgt_id, in0_sideband};
    pl1 = {in1_addr, in1_strb, in1_data, in1_opcode, in1_src_id, in1_tgt_id, in1_sideband};
    pl_mux = grant[1] ? pl1 : pl0;
  end

  // rdy is forced low while reset is held so nothing is accepted then.
  always_comb begin
    in0_rdy = rst_n & grant[0] & slot_rdy;
    in1_rdy = rst_n & grant[1] & slot_rdy;
    in_hs   = (in0_vld & in0_rdy) | (in1_vld & in1_rdy);
  end

  assign {out0_addr, out0_strb, out0_data, out0_opcode, out0_src_id, out0_tgt_id,
          out0_sideband} = pl_out;

`ifdef TOY_BUS_ARB_OUT_REG_EN

  logic           out_vld_q, out_vld_d;
  logic [PlW-1:0] pl_q, pl_d;

  // Slot refills in the same cycle it drains, giving one request per cycle.
  always_comb begin
    slot_rdy  = !out_vld_q || out0_rdy;
    out_vld_d = out_vld_q;
    pl_d      = pl_q;
    if (in_hs) begin
      out_vld_d = 1'b1;
      pl_d      = pl_mux;
    end else if (out0_rdy) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q <= 1'b0;
      pl_q      <= '0;
    end else begin
      out_vld_q <= out_vld_d;
      pl_q      <= pl_d;
    end
  end

  always_comb begin
    out0_vld = out_vld_q;
    pl_out   = pl_q;
  end

`else

  always_comb begin
    slot_rdy = out0_rdy;
    out0_vld = rst_n & (in0_vld | in1_vld);
    pl_out   = pl_mux;
  end

`endif

endmodule

// File: tb/tb_toy_bus_arb_node_dmem_req.sv
// Directed self-checking bench for toy_bus_arb_node_dmem_req. Works in both
// builds; latency-specific expectations follow TOY_BUS_ARB_OUT_REG_EN.
module tb_toy_bus_arb_node_dmem_req;

  localparam int DW = 256;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in0_vld, in0_rdy, in1_vld, in1_rdy, out0_vld, out0_rdy;
  logic [31:0]   in0_addr, in0_strb, in0_sideband, in1_addr, in1_strb, in1_sideband;
  logic [31:0]   out0_addr, out0_strb, out0_sideband;
  logic [DW-1:0] in0_data, in1_data, out0_data;
  logic [0:0]    in0_opcode, in1_opcode, out0_opcode;
  logic [IW-1:0] in0_src_id, in0_tgt_id, in1_src_id, in1_tgt_id, out0_src_id, out0_tgt_id;

  int checks = 0;
  int failures = 0;

  logic [IW-1:0] oq[$];
  logic [31:0]   cap_addr, cap_strb, cap_sb;
  logic [DW-1:0] cap_data;
  logic [0:0]    cap_opc;
  logic [IW-1:0] cap_src, cap_tgt;

  toy_bus_arb_node_dmem_req #(
    .DATA_W (DW),
    .ID_W   (IW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in0_vld       (in0_vld),
    .in0_rdy       (in0_rdy),
    .in0_addr      (in0_addr),
    .in0_strb      (in0_strb),
    .in0_data      (in0_data),
    .in0_opcode    (in0_opcode),
    .in0_src_id    (in0_src_id),
    .in0_tgt_id    (in0_tgt_id),
    .in0_sideband  (in0_sideband),
    .in1_vld       (in1_vld),
    .in1_rdy       (in1_rdy),
    .in1_addr      (in1_addr),
    .in1_strb      (in1_strb),
    .in1_data      (in1_data),
    .in1_opcode    (in1_opcode),
    .in1_src_id    (in1_src_id),
    .in1_tgt_id    (in1_tgt_id),
    .in1_sideband  (in1_sideband),
    .out0_vld      (out0_vld),
    .out0_rdy      (out0_rdy),
    .out0_addr     (out0_addr),
    .out0_strb     (out0_strb),
    .out0_data     (out0_data),
    .out0_opcode   (out0_opcode),
    .out0_src_id   (out0_src_id),
    .out0_tgt_id   (out0_tgt_id),
    .out0_sideband (out0_sideband)
  );

  always #5 clk = ~clk;

  // Output monitor: records every out0 handshake 1 ns before the rising edge.
  always begin
    @(negedge clk);
    #4;
    if (rst_n && out0_vld && out0_rdy) begin
      oq.push_back(out0_src_id);
      cap_addr = out0_addr;
      cap_strb = out0_strb;
      cap_sb   = out0_sideband;
      cap_data = out0_data;
      cap_opc  = out0_opcode;
      cap_src  = out0_src_id;
      cap_tgt  = out0_tgt_id;
    end
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_alt(input string tag, input int n, input int first);
    check({tag, "_count"}, oq.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < oq.size()) check($sformatf("%s_%0d", tag, i), oq[i], (i + first) % 2);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    out0_rdy = 1'b0;
    in0_vld = 1'b1;
    in1_vld = 1'b1;
    in0_addr = 32'h0; in0_strb = 32'h0; in0_data = '0; in0_opcode = 1'b0;
    in0_src_id = 4'd0; in0_tgt_id = 4'd0; in0_sideband = 32'h0;
    in1_addr = 32'h4; in1_strb = 32'hF; in1_data = '0; in1_opcode = 1'b1;
    in1_src_id = 4'd1; in1_tgt_id = 4'd2; in1_sideband = 32'h1;

    // Reset held with both requesters valid: nothing accepted or presented.
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_in0_rdy", in0_rdy, 0);
    check("rst_in1_rdy", in1_rdy, 0);
    check("rst_out0_vld", out0_vld, 0);
`ifdef TOY_BUS_ARB_OUT_REG_EN
    check("rst_payload", {out0_addr, out0_strb, out0_src_id}, 0);
`endif

    // Both valid from the first cycle after release: in0 first, then alternate.
    @(negedge clk);
    rst_n = 1'b1;
    out0_rdy = 1'b1;
    oq.delete();
    #1;
    check("t1_c0_in0_rdy", in0_rdy, 1);
    check("t1_c0_in1_rdy", in1_rdy, 0);
`ifdef TOY_BUS_ARB_OUT_REG_EN
    check("t1_c0_out0_vld", out0_vld, 0);
`else
    check("t1_c0_out0_vld", out0_vld, 1);
    check("t1_c0_out0_src", out0_src_id, 0);
`endif
    @(negedge clk);
    #1;
    check("t1_c1_in0_rdy", in0_rdy, 0);
    check("t1_c1_in1_rdy", in1_rdy, 1);
`ifdef TOY_BUS_ARB_OUT_REG_EN
    check("t1_c1_out0_vld", out0_vld, 1);
    check("t1_c1_out0_src", out0_src_id, 0);
`endif
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    in0_vld = 1'b0;
    in1_vld = 1'b0;
    @(negedge clk);
    #1;
    check_alt("t1_order", 4, 0);

    // Only in1 valid, src_id 1..4; in0 never gets rdy.
    oq.delete();
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      in1_vld = 1'b1;
      in1_src_id = 4'(i);
      #1;
      check($sformatf("t2_in0_rdy_%0d", i), in0_rdy, 0);
      check($sformatf("t2_in1_rdy_%0d", i), in1_rdy, 1);
    end
    @(negedge clk);
    in1_vld = 1'b0;
    in1_src_id = 4'd1;
    @(negedge clk);
    #1;
    check("t2_count", oq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < oq.size()) check($sformatf("t2_src_%0d", i), oq[i], i + 1);
    end

    // Stall with both valid: in0 (after in1) holds the grant, one request held.
    oq.delete();
    @(negedge clk);
    in0_vld = 1'b1;
    in1_vld = 1'b1;
    out0_rdy = 1'b0;
    #1;
    check("t3_s0_in1_rdy", in1_rdy, 0);
`ifdef TOY_BUS_ARB_OUT_REG_EN
    check("t3_s0_in0_rdy", in0_rdy, 1);
`else
    check("t3_s0_in0_rdy", in0_rdy, 0);
    check("t3_s0_out0_src", out0_src_id, 0);
`endif
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("t3_s%0d_in0_rdy", i), in0_rdy, 0);
      check($sformatf("t3_s%0d_in1_rdy", i), in1_rdy, 0);
      check($sformatf("t3_s%0d_vld", i), out0_vld, 1);
      check($sformatf("t3_s%0d_src", i), out0_src_id, 0);
    end
    @(negedge clk);
    out0_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    in0_vld = 1'b0;
    in1_vld = 1'b0;
    @(negedge clk);
    #1;
`ifdef TOY_BUS_ARB_OUT_REG_EN
    check_alt("t3_order", 5, 0);
`else
    check_alt("t3_order", 4, 0);
`endif

    // Field integrity through the node.
    oq.delete();
    @(negedge clk);
    in0_vld = 1'b1;
    in0_addr = 32'h0000_1000;
    in0_strb = 32'hA5A5_0F0F;
    in0_data = '1;
    in0_opcode = 1'b1;
    in0_src_id = 4'd5;
    in0_tgt_id = 4'd3;
    in0_sideband = 32'hDEAD_BEEF;
    @(negedge clk);
    in0_vld = 1'b0;
    @(negedge clk);
    #1;
    check("t4_count", oq.size(), 1);
    check("t4_addr", cap_addr, 32'h0000_1000);
    check("t4_strb", cap_strb, 32'hA5A5_0F0F);
    check("t4_data", cap_data, {DW{1'b1}});
    check("t4_opcode", cap_opc, 1);
    check("t4_src", cap_src, 5);
    check("t4_tgt", cap_tgt, 3);
    check("t4_sideband", cap_sb, 32'hDEAD_BEEF);
    in0_src_id = 4'd0;

    // last_grant is now 0 (in0 won); reset must put it back to 1.
    @(negedge clk);
    in0_vld = 1'b1;
    out0_rdy = 1'b0;
    @(negedge clk);
    in0_vld = 1'b0;
    #1;
`ifdef TOY_BUS_ARB_OUT_REG_EN
    check("t5_pre_vld", out0_vld, 1);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_vld", out0_vld, 0);
    check("t5_rst_in0_rdy", in0_rdy, 0);
    check("t5_rst_in1_rdy", in1_rdy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    in0_vld = 1'b1;
    in1_vld = 1'b1;
    out0_rdy = 1'b1;
    #1;
    check("t5_post_in0_rdy", in0_rdy, 1);
    check("t5_post_in1_rdy", in1_rdy, 0);
    @(negedge clk);
    in0_vld = 1'b0;
    in1_vld = 1'b0;
    @(negedge clk);

`ifndef TOY_BUS_ARB_OUT_REG_EN
    // Pass-through: in0_rdy tracks out0_rdy within the same cycle.
    @(negedge clk);
    in0_vld = 1'b1;
    out0_rdy = 1'b0;
    #1;
    check("t6_vld", out0_vld, 1);
    check("t6_rdy_lo", in0_rdy, 0);
    out0_rdy = 1'b1;
    #1;
    check("t6_rdy_hi", in0_rdy, 1);
    @(negedge clk);
    in0_vld = 1'b0;
    @(negedge clk);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
